// File: rtl/sort_result_overlay.sv
// ---------------------------------------------------------------------------
// sort_result_overlay : frame-rate class debouncer and 16-cell indicator strip
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort_result_overlay #(
  parameter int          STABLE_FRAMES = 4,
  parameter int          CELL_W        = 16,
  parameter int          BAR_H         = 16,
  parameter logic [23:0] HL_RGB        = 24'h00FF00,
  parameter logic [23:0] DIV_RGB       = 24'hFFFFFF
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic [23:0] i_rgb,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [3:0]  sort,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [3:0]  stable_sort,
  output logic        sort_valid
);

  localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);
  localparam logic [11:0] CELL_WL  = 12'(CELL_W);
  localparam logic [12:0] STRIP_W  = 13'(16 * CELL_W);
  localparam logic [10:0] BAR_HL   = 11'(BAR_H);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        sample_now;

  logic        fs;
  logic        de_fall;

  logic [3:0]  smp;
  logic        smp_vld;
  logic [3:0]  cand;
  logic [3:0]  cnt;
  logic [3:0]  cand_nxt;
  logic [3:0]  cnt_nxt;
  logic        accept;

  logic [11:0] x;
  logic [10:0] y;
  logic        strip_en;
  logic        in_strip;
  logic [11:0] cell_idx;
  logic [11:0] cell_off;
  logic [23:0] pix_nxt;

  // o_vsync / o_de double as the 1-cycle delayed copies used for edge detection
  assign fs      = i_vsync & ~o_vsync;
  assign de_fall = o_de & ~i_de;

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_now = 1'b0;
    case (state)
      ST_WAIT: begin
        if (fs) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        sample_now = fs;
      end
      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      smp     <= 4'd0;
      smp_vld <= 1'b0;
    end else begin
      smp_vld <= sample_now;
      if (sample_now) begin
        smp <= sort;
      end
    end
  end

  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (smp == cand) begin
      cnt_nxt = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
    end else begin
      cand_nxt = smp;
      cnt_nxt  = 4'd1;
    end
    accept = (cnt_nxt >= STABLE_N);
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      cand        <= 4'd0;
      cnt         <= 4'd0;
      stable_sort <= 4'd0;
      sort_valid  <= 1'b0;
    end else if (smp_vld) begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
      if (accept) begin
        stable_sort <= cand_nxt;
        sort_valid  <= |cand_nxt;
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      x <= 12'd0;
    end else if (i_de) begin
      if (x != 12'hFFF) begin
        x <= x + 12'd1;
      end
    end else begin
      x <= 12'd0;
    end
  end

  // strip_en keeps the strip off until y has been re-aligned by a frame start
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      y        <= 11'd0;
      strip_en <= 1'b0;
    end else if (fs) begin
      y        <= 11'd0;
      strip_en <= 1'b1;
    end else if (de_fall && (y != 11'h7FF)) begin
      y <= y + 11'd1;
    end
  end

  always_comb begin
    cell_idx = x / CELL_WL;
    cell_off = x % CELL_WL;
    in_strip = i_de & strip_en & (y < BAR_HL) & ({1'b0, x} < STRIP_W);
    pix_nxt  = i_rgb;
    if (in_strip) begin
      if (cell_off == 12'd0) begin
        pix_nxt = DIV_RGB;
      end else if (sort_valid && (cell_idx == {8'd0, stable_sort})) begin
        pix_nxt = HL_RGB;
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      o_rgb   <= 24'd0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_rgb   <= pix_nxt;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
      o_de    <= i_de;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sort_result_overlay.sv
// ---------------------------------------------------------------------------
// tb_sort_result_overlay : directed bench with a pixel scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sort_result_overlay;

  localparam int STABLE = 4;

  logic        pixelclk = 1'b0;
  logic        reset_n;
  logic [23:0] i_rgb;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_de;
  logic [3:0]  sort;
  logic [23:0] o_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [3:0]  stable_sort;
  logic        sort_valid;

  always #5 pixelclk = ~pixelclk;

  sort_result_overlay #(
    .STABLE_FRAMES(STABLE),
    .CELL_W       (16),
    .BAR_H        (16),
    .HL_RGB       (24'h00FF00),
    .DIV_RGB      (24'hFFFFFF)
  ) dut (
    .pixelclk   (pixelclk),
    .reset_n    (reset_n),
    .i_rgb      (i_rgb),
    .i_hsync    (i_hsync),
    .i_vsync    (i_vsync),
    .i_de       (i_de),
    .sort       (sort),
    .o_rgb      (o_rgb),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_de       (o_de),
    .stable_sort(stable_sort),
    .sort_valid (sort_valid)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } vid_t;

  vid_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic [3:0] m_stable;
  logic [3:0] m_cand;
  logic       m_valid;
  logic       m_run;
  logic       m_aligned;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(15));
  endfunction

  // One pixel clock: drive inputs, queue the expected output, compare it a cycle later
  task automatic step(input logic rn, input logic [23:0] rgb, input logic hs, input logic vs,
                      input logic de, input logic [3:0] s, input int x, input int y);
    vid_t e;
    vid_t exp_pix;
    reset_n = rn;
    i_rgb   = rgb;
    i_hsync = hs;
    i_vsync = vs;
    i_de    = de;
    sort    = s;
    e = '0;
    if (rn) begin
      e.rgb = rgb;
      e.hs  = hs;
      e.vs  = vs;
      e.de  = de;
      if (de && m_aligned && y < 16 && x < 256) begin
        if (x % 16 == 0) e.rgb = 24'hFFFFFF;
        else if (m_valid && (x / 16) == int'(m_stable)) e.rgb = 24'h00FF00;
      end
    end
    sb.push_back(e);
    @(negedge pixelclk);
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      exp_pix = sb.pop_front();
      chk($sformatf("video x=%0d y=%0d", x, y),
          32'({o_rgb, o_hsync, o_vsync, o_de}), 32'(exp_pix));
    end
  endtask

  task automatic do_reset(input int n, input logic de, input int y);
    m_stable  = 4'd0;
    m_cand    = 4'd0;
    m_valid   = 1'b0;
    m_cnt     = 0;
    m_run     = 1'b0;
    m_aligned = 1'b0;
    // vsync rises while reset is held; the frame start must be ignored
    for (int i = 0; i < n; i++)
      step(1'b0, 24'($urandom), 1'($urandom_range(1)), (i == 1), de, rnd4(), i, y);
    chk("reset stable_sort", 32'(stable_sort), 32'd0);
    chk("reset sort_valid",  32'(sort_valid),  32'd0);
    chk("reset cnt",         32'(dut.cnt),     32'd0);
  endtask

  task automatic frame(input logic [3:0] s, input bit video, input int rst_line,
                       input logic [23:0] rgb);
    logic [3:0] old_s;
    logic       old_v;
    int         nl;
    int         ll;
    old_s = m_stable;
    old_v = m_valid;
    if (m_run) begin
      if (s == m_cand) begin
        if (m_cnt < 15) m_cnt++;
      end else begin
        m_cand = s;
        m_cnt  = 1;
      end
      if (m_cnt >= STABLE) begin
        m_stable = m_cand;
        m_valid  = (m_cand != 4'd0);
      end
    end else begin
      m_run = 1'b1;
    end
    m_aligned = 1'b1;

    // only the sort value present on the vsync rising cycle may be sampled
    step(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, s, 0, 0);
    chk("stable_sort held at fs edge", 32'(stable_sort), 32'(old_s));
    chk("sort_valid held at fs edge",  32'(sort_valid),  32'(old_v));
    step(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, rnd4(), 0, 0);
    chk("stable_sort after fs", 32'(stable_sort), 32'(m_stable));
    chk("sort_valid after fs",  32'(sort_valid),  32'(m_valid));
    chk("cnt after fs",         32'(dut.cnt),     32'(m_cnt));
    step(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, rnd4(), 0, 0);
    step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, rnd4(), 0, 0);
    step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, rnd4(), 0, 0);

    nl = video ? 18 : 1;
    ll = video ? 272 : 4;
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) do_reset(3, 1'b1, l);
      for (int p = 0; p < ll; p++)
        step(1'b1, video ? rgb : 24'($urandom), 1'b0, 1'b0, 1'b1, rnd4(), p, l);
      for (int b = 0; b < 4; b++)
        step(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0, rnd4(), 0, l);
    end
  endtask

  initial begin
    int flick[6] = '{7, 3, 7, 3, 7, 3};
    reset_n   = 1'b0;
    i_rgb     = 24'd0;
    i_hsync   = 1'b0;
    i_vsync   = 1'b0;
    i_de      = 1'b0;
    sort      = 4'd0;
    m_stable  = 4'd0;
    m_cand    = 4'd0;
    m_valid   = 1'b0;
    m_cnt     = 0;
    m_run     = 1'b0;
    m_aligned = 1'b0;
    @(negedge pixelclk);

    do_reset(3, 1'b0, 0);

    // acceptance: first fs only leaves WAIT, accept on the 5th
    repeat (6) frame(4'd5, 1'b0, -1, 24'd0);
    chk("class 5 accepted", 32'(stable_sort), 32'd5);

    // flicker rejection then settle on 3
    repeat (4) frame(4'd7, 1'b0, -1, 24'd0);
    foreach (flick[i]) frame(4'(flick[i]), 1'b0, -1, 24'd0);
    chk("flicker keeps 7", 32'(stable_sort), 32'd7);
    repeat (4) frame(4'd3, 1'b0, -1, 24'd0);
    chk("class 3 accepted", 32'(stable_sort), 32'd3);

    // overlay geometry with class 2
    repeat (4) frame(4'd2, 1'b0, -1, 24'd0);
    frame(4'd2, 1'b1, -1, 24'h123456);

    // class 0 after class 4: dividers only
    repeat (4) frame(4'd4, 1'b0, -1, 24'd0);
    repeat (4) frame(4'd0, 1'b0, -1, 24'd0);
    chk("class 0 clears valid", 32'(sort_valid), 32'd0);
    frame(4'd0, 1'b1, -1, 24'h123456);

    // reset at line 8 with class 6 shown, then re-alignment
    repeat (4) frame(4'd6, 1'b0, -1, 24'd0);
    frame(4'd6, 1'b1, 8, 24'h123456);
    frame(4'd6, 1'b1, -1, 24'h123456);

    // saturation of the run counter and highlight of cell 9
    repeat (20) frame(4'd9, 1'b0, -1, 24'd0);
    chk("cnt saturated", 32'(dut.cnt), 32'd15);
    frame(4'd9, 1'b1, -1, 24'h123456);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
